// File: rtl/program_loader.sv
// program_loader: front end of the CPU program memory. Synchronises the
// external load_req / strobe pins, writes one captured byte per strobe rise
// while in LOAD, holds the CPU in reset during the load, and keeps a byte
// count and mod-2^WIDTH checksum of the bytes written.
module program_loader #(
  parameter int ADD_WIDTH   = 7,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_req,
  input  logic                 strobe,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 pm_wr_en,
  output logic [ADD_WIDTH-1:0] pm_addr,
  output logic [WIDTH-1:0]     pm_data,
  output logic                 cpu_hold,
  output logic                 loading,
  output logic                 full,
  output logic [ADD_WIDTH:0]   byte_count,
  output logic [WIDTH-1:0]     checksum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] ld_sync_q;
  logic [SYNC_STAGES-1:0] st_sync_q;
  logic                   st_prev_q;
  state_t                 state_q, state_d;

  logic [ADD_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADD_WIDTH:0]     count_q, count_d;
  logic [WIDTH-1:0]       ck_q, ck_d;
  logic                   full_q, full_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADD_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   hold_q, hold_d;
  logic                   loading_q, loading_d;

  logic load_s;
  logic strobe_s;
  logic edge_s;
  logic enter_load_s;
  logic wr_s;

  assign load_s   = ld_sync_q[SYNC_STAGES-1];
  assign strobe_s = st_sync_q[SYNC_STAGES-1];
  // Edge state is tracked in every state so a strobe already high on LOAD
  // entry cannot masquerade as a new byte.
  assign edge_s   = strobe_s & ~st_prev_q;

  // Synchroniser chains for the asynchronous pins plus strobe edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_sync_q <= '0;
      st_sync_q <= '0;
      st_prev_q <= 1'b0;
    end else begin
      ld_sync_q <= {ld_sync_q[SYNC_STAGES-2:0], load_req};
      st_sync_q <= {st_sync_q[SYNC_STAGES-2:0], strobe};
      st_prev_q <= strobe_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE lasts one cycle, then load_req selects LOAD or RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = load_s ? ST_LOAD : ST_RUN;
      ST_LOAD: state_d = load_s ? ST_LOAD : ST_RUN;
      ST_RUN:  state_d = load_s ? ST_LOAD : ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // A write is decided on the current state, so an edge coinciding with the
  // load_req drop still lands (its pulse appears alongside cpu_hold=0).
  assign enter_load_s = (state_q != ST_LOAD) && (state_d == ST_LOAD);
  assign wr_s         = (state_q == ST_LOAD) && edge_s && !full_q;

  // Datapath next-state: load-entry clearing, byte write, counters, outputs.
  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    ck_d      = ck_q;
    full_d    = full_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    hold_d    = (state_d != ST_RUN);
    loading_d = (state_d == ST_LOAD);
    if (enter_load_s) begin
      ptr_d   = '0;
      count_d = '0;
      ck_d    = '0;
      full_d  = 1'b0;
    end else if (wr_s) begin
      wr_en_d = 1'b1;
      addr_d  = ptr_q;
      data_d  = data_in;
      count_d = count_q + 1'b1;
      ck_d    = ck_q + data_in;
      if (ptr_q == '1) begin
        // Last address: saturate rather than wrap and block further writes.
        full_d = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      count_q   <= '0;
      ck_q      <= '0;
      full_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      hold_q    <= 1'b1;
      loading_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      ck_q      <= ck_d;
      full_q    <= full_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      hold_q    <= hold_d;
      loading_q <= loading_d;
    end
  end

  assign pm_wr_en   = wr_en_q;
  assign pm_addr    = addr_q;
  assign pm_data    = data_q;
  assign cpu_hold   = hold_q;
  assign loading    = loading_q;
  assign full       = full_q;
  assign byte_count = count_q;
  assign checksum   = ck_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed, table-driven bench for program_loader
// (SYNC_STAGES=2). Inputs change and outputs are sampled on the falling edge.
module tb_program_loader;

  logic       clk;
  logic       rst;
  logic       load_req;
  logic       strobe;
  logic [7:0] data_in;
  logic       pm_wr_en;
  logic [6:0] pm_addr;
  logic [7:0] pm_data;
  logic       cpu_hold;
  logic       loading;
  logic       full;
  logic [7:0] byte_count;
  logic [7:0] checksum;

  int n_cmp;
  int n_bad;
  int pulse_cnt;

  program_loader #(.ADD_WIDTH(7), .WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .strobe     (strobe),
    .data_in    (data_in),
    .pm_wr_en   (pm_wr_en),
    .pm_addr    (pm_addr),
    .pm_data    (pm_data),
    .cpu_hold   (cpu_hold),
    .loading    (loading),
    .full       (full),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write pulses shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (pm_wr_en) pulse_cnt = pulse_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic [6:0] exp_addr;
    logic [7:0] exp_ck;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t basic [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Deliver one byte: 4 cycles data setup, 4 cycles strobe high, 4 low.
  // A write must appear exactly on the third falling edge after the rise.
  task automatic send_byte(input logic [7:0] d, input logic exp_wr,
                           input logic [6:0] ea, input logic [7:0] eck,
                           input logic [7:0] ecnt, input logic efull);
    data_in = d;
    repeat (4) @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    check("wr_early1", 32'(pm_wr_en), 32'(0));
    @(negedge clk);
    check("wr_early2", 32'(pm_wr_en), 32'(0));
    @(negedge clk);
    check("wr_pulse", 32'(pm_wr_en), 32'(exp_wr));
    if (exp_wr) begin
      check("wr_addr", 32'(pm_addr), 32'(ea));
      check("wr_data", 32'(pm_data), 32'(d));
    end
    check("byte_count", 32'(byte_count), 32'(ecnt));
    check("checksum", 32'(checksum), 32'(eck));
    check("full", 32'(full), 32'(efull));
    @(negedge clk);
    check("wr_single", 32'(pm_wr_en), 32'(0));
    strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Change load_req; mode outputs must switch on the third falling edge.
  task automatic set_mode(input logic lr, input logic prev);
    load_req = lr;
    @(negedge clk);
    @(negedge clk);
    check("mode_hold_loading", 32'(loading), 32'(prev));
    check("mode_hold_cpu", 32'(cpu_hold), 32'(prev));
    @(negedge clk);
    check("mode_loading", 32'(loading), 32'(lr));
    check("mode_cpu_hold", 32'(cpu_hold), 32'(lr));
  endtask

  initial begin
    logic [7:0] ck_m;
    int         p0;

    n_cmp = 0;
    n_bad = 0;
    pulse_cnt = 0;

    basic[0] = '{data: 8'h13, exp_addr: 7'd0, exp_ck: 8'h13, exp_cnt: 8'd1};
    basic[1] = '{data: 8'h05, exp_addr: 7'd1, exp_ck: 8'h18, exp_cnt: 8'd2};
    basic[2] = '{data: 8'h10, exp_addr: 7'd2, exp_ck: 8'h28, exp_cnt: 8'd3};
    basic[3] = '{data: 8'h00, exp_addr: 7'd3, exp_ck: 8'h28, exp_cnt: 8'd4};

    // Reset with load_req already high.
    rst = 1'b0;
    load_req = 1'b1;
    strobe = 1'b0;
    data_in = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_cpu_hold", 32'(cpu_hold), 32'(1));
    check("rst_wr_en", 32'(pm_wr_en), 32'(0));
    check("rst_loading", 32'(loading), 32'(0));
    check("rst_full", 32'(full), 32'(0));
    check("rst_count", 32'(byte_count), 32'(0));
    check("rst_checksum", 32'(checksum), 32'(0));
    check("rst_addr", 32'(pm_addr), 32'(0));
    check("rst_data", 32'(pm_data), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rel_loading_early", 32'(loading), 32'(0));
    @(negedge clk);
    check("rel_loading", 32'(loading), 32'(1));
    check("rel_cpu_hold", 32'(cpu_hold), 32'(1));

    // Basic 4-byte load.
    for (int i = 0; i < 4; i++) begin
      send_byte(basic[i].data, 1'b1, basic[i].exp_addr, basic[i].exp_ck,
                basic[i].exp_cnt, 1'b0);
    end
    set_mode(1'b0, 1'b1);
    check("basic_count", 32'(byte_count), 32'(4));
    check("basic_checksum", 32'(checksum), 32'(8'h28));

    // Full: 130 bytes of 0xFF, only 128 written.
    set_mode(1'b1, 1'b0);
    check("full_clr_count", 32'(byte_count), 32'(0));
    check("full_clr_ck", 32'(checksum), 32'(0));
    p0 = pulse_cnt;
    ck_m = 8'h00;
    for (int i = 0; i < 130; i++) begin
      if (i < 128) ck_m = ck_m + 8'hFF;
      send_byte(8'hFF, (i < 128), 7'(i < 128 ? i : 127), ck_m,
                8'(i < 128 ? i + 1 : 128), (i >= 127));
    end
    check("full_pulses", 32'(pulse_cnt - p0), 32'(128));
    check("full_checksum", 32'(checksum), 32'(8'h80));
    check("full_count", 32'(byte_count), 32'(128));

    // RUN: results persist, strobes ignored.
    set_mode(1'b0, 1'b1);
    p0 = pulse_cnt;
    send_byte(8'h5A, 1'b0, 7'd0, 8'h80, 8'd128, 1'b1);
    check("run_no_pulse", 32'(pulse_cnt - p0), 32'(0));

    // Strobe held high across LOAD entry: no write.
    strobe = 1'b1;
    data_in = 8'h77;
    repeat (4) @(negedge clk);
    set_mode(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("hold_no_pulse", 32'(pulse_cnt - p0), 32'(0));
    check("hold_count", 32'(byte_count), 32'(0));
    check("hold_full", 32'(full), 32'(0));
    strobe = 1'b0;
    repeat (4) @(negedge clk);

    // Reload: one byte at address 0.
    send_byte(8'hAA, 1'b1, 7'd0, 8'hAA, 8'd1, 1'b0);

    // Mid-load reset: fresh LOAD, two bytes, reset with a third pending.
    set_mode(1'b0, 1'b1);
    set_mode(1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 7'd0, 8'h11, 8'd1, 1'b0);
    send_byte(8'h22, 1'b1, 7'd1, 8'h33, 8'd2, 1'b0);
    data_in = 8'h33;
    repeat (4) @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    p0 = pulse_cnt;
    rst = 1'b0;
    #1;
    check("mid_wr_en", 32'(pm_wr_en), 32'(0));
    check("mid_cpu_hold", 32'(cpu_hold), 32'(1));
    check("mid_loading", 32'(loading), 32'(0));
    check("mid_count", 32'(byte_count), 32'(0));
    check("mid_checksum", 32'(checksum), 32'(0));
    check("mid_addr", 32'(pm_addr), 32'(0));
    repeat (3) @(negedge clk);
    check("mid_no_pulse", 32'(pulse_cnt - p0), 32'(0));
    strobe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_reload", 32'(loading), 32'(1));
    send_byte(8'h44, 1'b1, 7'd0, 8'h44, 8'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
